// File: rtl/sseg_mux_ctrl.sv
// Time-multiplexed common-anode 7-segment controller with double-buffered
// loading, per-digit blank/blink, leading-zero suppression and PWM dimming.

module sseg_mux_ctrl #(
   parameter int DIGITS       = 4,
   parameter int REFRESH_LOG2 = 16,
   parameter int BLINK_FRAMES = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [4*DIGITS-1:0] hex_in,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic [DIGITS-1:0]   blank_in,
   input  logic [DIGITS-1:0]   blink_in,
   input  logic                load,
   input  logic                lz_en,
   input  logic [3:0]          bright,
   output logic [DIGITS-1:0]   an,
   output logic [7:0]          sseg,
   output logic                frame_tick
);

   localparam int IW = $clog2(DIGITS);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [IW-1:0] LAST_DIGIT = IW'(DIGITS - 1);
   localparam logic [BW-1:0] LAST_BLINK = BW'(BLINK_FRAMES - 1);

   // One complete set of display data for all digits.
   typedef struct packed {
      logic [DIGITS-1:0][3:0] hex;
      logic [DIGITS-1:0]      dp;
      logic [DIGITS-1:0]      blank;
      logic [DIGITS-1:0]      blink;
   } disp_t;

   // Blank everything until the first load reaches the shadow copy.
   localparam disp_t DISP_RESET = '{
      hex:   '0,
      dp:    '0,
      blank: '1,
      blink: '0
   };

   logic [REFRESH_LOG2-1:0] slot_cnt;
   logic [IW-1:0]           digit_idx;
   logic [BW-1:0]           blink_cnt;
   logic                    blink_phase;

   disp_t                   live;
   disp_t                   staging;
   disp_t                   shadow;
   logic                    pending;

   logic                    slot_wrap;
   logic                    boundary;
   logic [3:0]              pwm_phase;
   logic                    pwm_on;
   logic [DIGITS-1:0]       lz_sup;
   logic                    zero_run;
   logic [3:0]              cur_hex;
   logic                    cur_dp;
   logic                    dark;
   logic [6:0]              cur_seg;
   logic [DIGITS-1:0]       an_on;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      unique case (v)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         4'hF: s = 7'b0111000;
      endcase
      return s;
   endfunction

   assign live.hex   = hex_in;
   assign live.dp    = dp_in;
   assign live.blank = blank_in;
   assign live.blink = blink_in;

   assign slot_wrap = &slot_cnt;
   assign boundary  = slot_wrap && (digit_idx == LAST_DIGIT);

   // PWM compares the top four slot bits against the live brightness.
   assign pwm_phase = slot_cnt[REFRESH_LOG2-1 -: 4];
   assign pwm_on    = (bright == 4'hF) || (pwm_phase < bright);

   // Walk down from the most significant digit; a digit is a leading zero
   // while every digit from it upward is zero and it carries no dp.
   always_comb begin
      zero_run = 1'b1;
      lz_sup   = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run  = zero_run && (shadow.hex[i] == 4'h0);
         lz_sup[i] = zero_run && !shadow.dp[i];
      end
   end

   assign cur_hex = shadow.hex[digit_idx];
   assign cur_dp  = shadow.dp[digit_idx];
   assign cur_seg = seg_decode(cur_hex);
   assign an_on   = ~(DIGITS'(1) << digit_idx);

   assign dark = shadow.blank[digit_idx]
              || (shadow.blink[digit_idx] && blink_phase)
              || (lz_en && lz_sup[digit_idx]);

   // Slot counter free-runs; the digit index steps on every slot wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_cnt  <= '0;
         digit_idx <= '0;
      end else begin
         slot_cnt <= slot_cnt + 1'b1;
         if (slot_wrap) begin
            if (digit_idx == LAST_DIGIT) begin
               digit_idx <= '0;
            end else begin
               digit_idx <= digit_idx + 1'b1;
            end
         end
      end
   end

   // Double buffer: loads land in staging and are promoted at the frame
   // boundary; a load in the boundary cycle bypasses staging entirely.
   always_ff @(posedge clk) begin
      if (reset) begin
         staging <= DISP_RESET;
         shadow  <= DISP_RESET;
         pending <= 1'b0;
      end else if (boundary) begin
         if (load) begin
            shadow <= live;
         end else if (pending) begin
            shadow <= staging;
         end
         pending <= 1'b0;
      end else if (load) begin
         staging <= live;
         pending <= 1'b1;
      end
   end

   // Blink phase flips after every BLINK_FRAMES frame boundaries.
   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (boundary) begin
         if (blink_cnt == LAST_BLINK) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // Registered pin drivers: the current digit, or fully dark.
   always_ff @(posedge clk) begin
      if (reset) begin
         an         <= '1;
         sseg       <= 8'hFF;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= boundary;
         if (dark || !pwm_on) begin
            an   <= '1;
            sseg <= 8'hFF;
         end else begin
            an   <= an_on;
            sseg <= {~cur_dp, cur_seg};
         end
      end
   end

endmodule
